// File: rtl/phase_pkg.sv
// Shared phase definitions: 2-bit Gray phase codes used by the phase decoder and phase_cycler.
package phase_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_0   = 2'b11;
  localparam phase_t PH_90  = 2'b10;
  localparam phase_t PH_180 = 2'b00;
  localparam phase_t PH_270 = 2'b01;

endpackage

// File: rtl/iq_rotator.sv
// Second sample stage: rotates registered I/Q by a Gray-coded quarter-turn.
// Macro PHASE_CYCLER_SAT_EN selects saturating negation instead of wrapping negation.
module iq_rotator
  import phase_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_p1,
  input  logic signed [DW-1:0] i_p1,
  input  logic signed [DW-1:0] q_p1,
  input  logic [1:0]           ph_p1,
  output logic                 vld_p2,
  output logic signed [DW-1:0] i_p2,
  output logic signed [DW-1:0] q_p2
);

  localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};

  function automatic logic signed [DW-1:0] neg(input logic signed [DW-1:0] x);
`ifdef PHASE_CYCLER_SAT_EN
    // -MIN is not representable; clamp to the largest positive value
    if (x == S_MIN) return S_MAX;
    return -x;
`else
    return -x;
`endif
  endfunction

  logic signed [DW-1:0] i_rot;
  logic signed [DW-1:0] q_rot;

  always_comb begin
    i_rot = i_p1;
    q_rot = q_p1;
    case (phase_t'(ph_p1))
      PH_90: begin
        i_rot = neg(q_p1);
        q_rot = i_p1;
      end
      PH_180: begin
        i_rot = neg(i_p1);
        q_rot = neg(q_p1);
      end
      PH_270: begin
        i_rot = q_p1;
        q_rot = neg(i_p1);
      end
      default: begin
        i_rot = i_p1;
        q_rot = q_p1;
      end
    endcase
  end

  // stage p1 -> p2: rotated result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      i_p2   <= '0;
      q_p2   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        i_p2 <= i_rot;
        q_p2 <= q_rot;
      end
    end
  end

endmodule

// File: rtl/phase_cycler.sv
// Per-scan NMR phase cycling of the transmit I/Q stream: steps through Gray phase codes on
// scan_start and rotates samples (2-cycle latency). Optional macro: PHASE_CYCLER_SAT_EN.
module phase_cycler
  import phase_pkg::*;
#(
  parameter int N_phases = 1,
  parameter int DW       = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [2*N_phases-1:0]                         phase_binary,
  input  logic                                          scan_start,
  input  logic                                          clear,
  input  logic                                          in_valid,
  input  logic signed [DW-1:0]                          i_in,
  input  logic signed [DW-1:0]                          q_in,
  output logic                                          out_valid,
  output logic signed [DW-1:0]                          i_out,
  output logic signed [DW-1:0]                          q_out,
  output logic [1:0]                                    phase_cur,
  output logic [((N_phases > 1) ? $clog2(N_phases) : 1)-1:0] step_idx,
  output logic                                          cycle_wrap
);

  localparam int STEP_W = (N_phases > 1) ? $clog2(N_phases) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(N_phases - 1);
  localparam logic [STEP_W-1:0] STEP_AFTER0 = STEP_W'((N_phases > 1) ? 1 : 0);

  phase_t step_code;

  always_comb begin
    step_code = phase_binary[1:0];
    for (int k = 0; k < N_phases; k++) begin
      if (step_idx == STEP_W'(k)) step_code = phase_binary[2*k +: 2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cur  <= PH_0;
      step_idx   <= '0;
      cycle_wrap <= 1'b0;
    end else begin
      cycle_wrap <= 1'b0;
      if (clear && scan_start) begin
        phase_cur <= phase_binary[1:0];
        step_idx  <= STEP_AFTER0;
      end else if (clear) begin
        phase_cur <= PH_0;
        step_idx  <= '0;
      end else if (scan_start) begin
        phase_cur <= step_code;
        if (step_idx == STEP_LAST) begin
          step_idx   <= '0;
          cycle_wrap <= 1'b1;
        end else begin
          step_idx <= step_idx + 1'b1;
        end
      end
    end
  end

  logic                 vld_p1;
  logic signed [DW-1:0] i_p1;
  logic signed [DW-1:0] q_p1;
  phase_t               ph_p1;

  // stage p0 -> p1: capture sample with the phase active in its own cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      i_p1  <= i_in;
      q_p1  <= q_in;
      ph_p1 <= phase_cur;
    end
  end

  iq_rotator #(.DW(DW)) u_rot (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_p1 (vld_p1),
    .i_p1   (i_p1),
    .q_p1   (q_p1),
    .ph_p1  (ph_p1),
    .vld_p2 (out_valid),
    .i_p2   (i_out),
    .q_p2   (q_out)
  );

endmodule

// File: tb/tb_phase_cycler.sv
// Directed bench for phase_cycler: a 4-step instance and a 1-step instance on a shared clock/reset.
module tb_phase_cycler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-step instance
  logic [7:0]          pb4;
  logic                scan4, clr4, iv4;
  logic signed [15:0]  i4, q4;
  logic                ov4;
  logic signed [15:0]  io4, qo4;
  logic [1:0]          ph4;
  logic [1:0]          st4;
  logic                wr4;

  // 1-step instance
  logic [1:0]          pb1;
  logic                scan1, clr1, iv1;
  logic signed [15:0]  i1, q1;
  logic                ov1;
  logic signed [15:0]  io1, qo1;
  logic [1:0]          ph1;
  logic [0:0]          st1;
  logic                wr1;

  phase_cycler #(.N_phases(4), .DW(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .phase_binary(pb4), .scan_start(scan4), .clear(clr4),
    .in_valid(iv4), .i_in(i4), .q_in(q4), .out_valid(ov4), .i_out(io4), .q_out(qo4),
    .phase_cur(ph4), .step_idx(st4), .cycle_wrap(wr4)
  );

  phase_cycler #(.N_phases(1), .DW(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .phase_binary(pb1), .scan_start(scan1), .clear(clr1),
    .in_valid(iv1), .i_in(i1), .q_in(q1), .out_valid(ov1), .i_out(io1), .q_out(qo1),
    .phase_cur(ph1), .step_idx(st1), .cycle_wrap(wr1)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected outputs for I=1000,Q=200 at entries 0..3 (0, 90, 180, 270 degrees)
  int exp_i [4] = '{1000, -200, -1000, 200};
  int exp_q [4] = '{200, 1000, -200, -1000};
  int exp_ph[4] = '{3, 2, 0, 1};
  int sat_exp;

  initial begin
    pb4 = 8'b01_00_10_11;
    scan4 = 0; clr4 = 0; iv4 = 0; i4 = 0; q4 = 0;
    pb1 = 2'b10;
    scan1 = 0; clr1 = 0; iv1 = 0; i1 = 0; q1 = 0;

    #12;
    check("rst_out_valid", int'(ov4), 0);
    check("rst_i_out", int'(io4), 0);
    check("rst_q_out", int'(qo4), 0);
    check("rst_phase_cur", int'(ph4), 3);
    check("rst_step_idx", int'(st4), 0);
    check("rst_cycle_wrap", int'(wr4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // full 4-step cycle, one sample per scan
    for (int k = 0; k < 4; k++) begin
      scan4 = 1; tick(); scan4 = 0;
      check($sformatf("cyc%0d_phase", k), int'(ph4), exp_ph[k]);
      check($sformatf("cyc%0d_step", k), int'(st4), (k + 1) % 4);
      check($sformatf("cyc%0d_wrap", k), int'(wr4), (k == 3) ? 1 : 0);
      iv4 = 1; i4 = 1000; q4 = 200; tick(); iv4 = 0;
      check($sformatf("cyc%0d_wrap_after", k), int'(wr4), 0);
      check($sformatf("cyc%0d_ov_early", k), int'(ov4), 0);
      tick();
      check($sformatf("cyc%0d_ov", k), int'(ov4), 1);
      check($sformatf("cyc%0d_i", k), int'(io4), exp_i[k]);
      check($sformatf("cyc%0d_q", k), int'(qo4), exp_q[k]);
    end

    // sample coincident with scan_start keeps the old (270) phase; next sample gets entry 0
    scan4 = 1; iv4 = 1; i4 = 1000; q4 = 200; tick();
    scan4 = 0; i4 = 300; q4 = -50; tick();
    iv4 = 0;
    check("bnd_old_ov", int'(ov4), 1);
    check("bnd_old_i", int'(io4), 200);
    check("bnd_old_q", int'(qo4), -1000);
    tick();
    check("bnd_new_ov", int'(ov4), 1);
    check("bnd_new_i", int'(io4), 300);
    check("bnd_new_q", int'(qo4), -50);
    tick();
    check("bnd_idle_ov", int'(ov4), 0);

    // reach step_idx=2, then clear+scan_start together, then clear alone
    scan4 = 1; tick(); scan4 = 0;
    check("pre_clr_step", int'(st4), 2);
    check("pre_clr_phase", int'(ph4), 2);
    clr4 = 1; scan4 = 1; tick(); clr4 = 0; scan4 = 0;
    check("clrscan_phase", int'(ph4), 3);
    check("clrscan_step", int'(st4), 1);
    check("clrscan_wrap", int'(wr4), 0);
    scan4 = 1; tick(); scan4 = 0;
    check("mid_phase", int'(ph4), 2);
    clr4 = 1; tick(); clr4 = 0;
    check("clr_phase", int'(ph4), 3);
    check("clr_step", int'(st4), 0);
    check("clr_wrap", int'(wr4), 0);

    // phase_binary changes between scans must not disturb phase_cur
    pb4 = 8'b11_11_11_01; tick();
    check("pb_change_phase", int'(ph4), 3);
    pb4 = 8'b01_00_10_11;

    // negation of the most negative value at 180 degrees
    for (int k = 0; k < 3; k++) begin
      scan4 = 1; tick(); scan4 = 0;
    end
    check("sat_phase", int'(ph4), 0);
    iv4 = 1; i4 = -32768; q4 = 0; tick(); iv4 = 0; tick();
`ifdef PHASE_CYCLER_SAT_EN
    sat_exp = 32767;
`else
    sat_exp = -32768;
`endif
    check("sat_i", int'(io4), sat_exp);
    check("sat_q", int'(qo4), 0);

    // single-step cycle: every scan wraps, step stays 0
    for (int k = 0; k < 3; k++) begin
      scan1 = 1; tick(); scan1 = 0;
      check($sformatf("n1_scan%0d_wrap", k), int'(wr1), 1);
      check($sformatf("n1_scan%0d_step", k), int'(st1), 0);
      check($sformatf("n1_scan%0d_phase", k), int'(ph1), 2);
      tick();
      check($sformatf("n1_scan%0d_wrap_after", k), int'(wr1), 0);
    end

    // continuous stream at 90 degrees: out = (-Q, I)
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        iv1 = 1; i1 = 16'(100 + 10 * k); q1 = 16'(-(k + 1));
      end else begin
        iv1 = 0;
      end
      tick();
      if (k >= 1 && k <= 5) begin
        check($sformatf("n1_str%0d_ov", k - 1), int'(ov1), 1);
        check($sformatf("n1_str%0d_i", k - 1), int'(io1), k);
        check($sformatf("n1_str%0d_q", k - 1), int'(qo1), 100 + 10 * (k - 1));
      end
    end
    check("n1_str_end_ov", int'(ov1), 0);

    // reset in the middle of a 10-sample burst
    for (int k = 0; k < 5; k++) begin
      iv4 = 1; i4 = 16'(500 + k); q4 = 16'(k); tick();
    end
    check("prerst_ov", int'(ov4), 1);
    check("prerst_phase", int'(ph4), 0);
    rst_n = 1'b0;
    #2;
    check("midrst_ov", int'(ov4), 0);
    check("midrst_i", int'(io4), 0);
    check("midrst_q", int'(qo4), 0);
    check("midrst_phase", int'(ph4), 3);
    check("midrst_step", int'(st4), 0);
    iv4 = 0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("postrst%0d_ov", k), int'(ov4), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/phase_cycler.md
# phase_cycler

Applies per-scan NMR phase cycling to the transmit I/Q sample stream. It consumes the packed array of 2-bit Gray phase codes from the phase decoder, one code per step of the cycle. It steps through the codes on each scan start and rotates incoming 16-bit I/Q samples by 0/90/180/270°. It sits between the phase decoder and the DAC sample path.

## Interface
Parameters:
- N_phases, 1: number of steps in the phase cycle; must be ≥ 1.
- DW, 16: signed I/Q sample width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- phase_binary  in  2*N_phases  packed Gray codes; step k occupies bits [2k+1:2k].
- scan_start  in  1  single-cycle pulse that advances the cycle.
- clear  in  1  synchronous restart of the cycle.
- in_valid  in  1  qualifies i_in/q_in.
- i_in, q_in  in  DW  signed input samples.
- out_valid  out  1  qualifies i_out/q_out.
- i_out, q_out  out  DW  signed rotated samples.
- phase_cur  out  2  active Gray code.
- step_idx  out  max(1,$clog2(N_phases))  index of the next step to load.
- cycle_wrap  out  1  one-cycle pulse when the cycle completes.

## Operation
Gray code map: 11 = 0°, 10 = 90°, 00 = 180°, 01 = 270°.

Rotation, with `neg()` as the negation defined under Configuration:
- 0°: (I, Q)
- 90°: (neg(Q), I)
- 180°: (neg(I), neg(Q))
- 270°: (Q, neg(I))

Step control. Priority is clear+scan_start > clear > scan_start.
- scan_start alone: phase_cur ← phase_binary[step_idx]. step_idx ← step_idx+1, wrapping to 0 after N_phases−1. cycle_wrap pulses on the wrap.
- clear alone: step_idx ← 0 and phase_cur ← 11. No cycle_wrap.
- clear and scan_start together: phase_cur ← entry 0 and step_idx ← 1 (0 if N_phases = 1). No cycle_wrap.
- N_phases = 1: step_idx stays 0, and every scan_start pulses cycle_wrap.
- phase_binary is sampled only on scan_start. Changes between scans do not affect phase_cur.

Sample path:
- No backpressure. Every in_valid sample produces exactly one output.
- Samples are never dropped or reordered.

## Timing
Reset values: phase_cur = 11, step_idx = 0, cycle_wrap = 0, out_valid = 0, i_out = 0, q_out = 0. All pipeline valid bits are cleared.

Sample pipeline, 2 stages, latency 2:
- Edge 1 registers i_in, q_in, in_valid and the current phase_cur.
- Edge 2 registers the rotated result and out_valid.
- Sustained throughput is one sample per cycle.

Phase boundary:
- A sample with in_valid in the same cycle as scan_start uses the old phase_cur.
- Samples from the next cycle onward use the new phase_cur.
- Phase is captured per sample at stage 1, so samples already in flight keep their own phase.

Step updates:
- phase_cur, step_idx and cycle_wrap update on the edge that samples scan_start.
- cycle_wrap is high for exactly the following cycle.

Reset mid-stream: asserting rst_n low immediately forces all outputs to their reset values. In-flight samples are discarded.

## Configuration
The macro PHASE_CYCLER_SAT_EN selects the behaviour of `neg(x)`.
- Defined: saturating negation, neg(−2^(DW−1)) = 2^(DW−1)−1. Otherwise neg(x) = −x.
- Undefined: plain two's-complement negation, so neg(−2^(DW−1)) = −2^(DW−1) (wraps).
- No other behaviour differs.

## Structure
Shared package phase_pkg holds:
- The Gray-code constants PH_0 = 2'b11, PH_90 = 2'b10, PH_180 = 2'b00, PH_270 = 2'b01.
- The phase_t 2-bit typedef. The phase decoder uses this same typedef.

Sub-module iq_rotator holds pipeline stage 2: it takes registered I/Q plus a phase code and produces the registered rotated I/Q, including `neg()`. Step control stays in phase_cycler.

## Test plan
- Reset, then N_phases=4 with phase_binary = {01,00,10,11}. Issue 4 scan_starts with a sample I=1000, Q=200 each scan. Outputs must be (1000,200), (−200,1000), (−1000,−200), (200,−1000). cycle_wrap must pulse once, after the 4th scan_start.
- in_valid in the same cycle as scan_start → that sample uses the old phase. The next sample uses the new phase. Both emerge exactly 2 cycles after input.
- I = −32768 at 180°, Q = 0: with PHASE_CYCLER_SAT_EN, i_out = 32767. Without it, i_out = −32768.
- clear and scan_start asserted together mid-cycle (step_idx=2) → phase_cur = entry 0, step_idx = 1, no cycle_wrap. clear alone → step_idx = 0, phase_cur = 11.
- N_phases=1, 3 scan_starts → step_idx stays 0 and cycle_wrap pulses 3 times. Streaming samples continuously gives out_valid continuous, 2-cycle latency.
- Assert rst_n low during a burst of 10 samples → out_valid, i_out, q_out, phase_cur and step_idx return to their reset values immediately. No stale samples appear after release.
